// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master block.
// Optional feature macro: SPI_MASTER_CS_HOLD_EN.
package spi_pkg;

    localparam int SPI_DEFAULT_CLK_DIV = 4;
    localparam int SPI_DEFAULT_DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LO,
        HI,
        GAP,
        HOLD
    } spi_state_e;

endpackage

// File: rtl/spi_half_period_timer.sv
// Down-counter that measures one SCLK half-period of CLK_DIV clk cycles.
// Load restarts the count; tick marks the last cycle of the phase.
module spi_half_period_timer #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= RELOAD;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign tick = (cnt_q == '0);

endmodule

// File: rtl/spi_master.sv
// Single-word mode-0 SPI master; all pin outputs are registered.
// Define SPI_MASTER_CS_HOLD_EN to add the hold port and HOLD state.
module spi_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_DEFAULT_CLK_DIV,
    parameter int DATA_W  = SPI_DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
`ifdef SPI_MASTER_CS_HOLD_EN
    input  logic              hold,
`endif
    input  logic [DATA_W-1:0] tx_data,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] rx_data,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
    localparam logic [BW-1:0] ALL_BITS = BW'(DATA_W);

    spi_state_e        state_q, state_d;
    logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              mosi_q, mosi_d;
    logic              sclk_q, sclk_d;
    logic              cs_n_q, cs_n_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              adv_q, adv_d;
    logic              tick;
    logic              load;
`ifdef SPI_MASTER_CS_HOLD_EN
    logic              hold_q, hold_d;
`endif

    // Every phase change restarts the half-period count.
    assign load = (state_d != state_q);

    spi_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (load),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            mosi_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            adv_q     <= 1'b0;
`ifdef SPI_MASTER_CS_HOLD_EN
            hold_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            mosi_q    <= mosi_d;
            sclk_q    <= sclk_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            adv_q     <= adv_d;
`ifdef SPI_MASTER_CS_HOLD_EN
            hold_q    <= hold_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        mosi_d    = mosi_q;
        sclk_d    = sclk_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        adv_d     = 1'b0;
`ifdef SPI_MASTER_CS_HOLD_EN
        hold_d    = hold_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    tx_sh_d   = tx_data;
                    mosi_d    = tx_data[DATA_W-1];
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = LO;
`ifdef SPI_MASTER_CS_HOLD_EN
                    hold_d    = hold;
`endif
                end
            end
            LO: begin
                // mosi moves one cycle after the falling edge.
                if (adv_q) begin
                    tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                    mosi_d  = tx_sh_q[DATA_W-2];
                end
                if (tick) begin
                    if (bit_cnt_q != ALL_BITS) begin
                        sclk_d  = 1'b1;
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], miso};
                        state_d = HI;
                    end else begin
                        done_d    = 1'b1;
                        rx_data_d = rx_sh_q;
`ifdef SPI_MASTER_CS_HOLD_EN
                        if (hold_q) begin
                            busy_d  = 1'b0;
                            state_d = HOLD;
                        end else begin
                            cs_n_d  = 1'b1;
                            state_d = GAP;
                        end
`else
                        cs_n_d  = 1'b1;
                        state_d = GAP;
`endif
                    end
                end
            end
            HI: begin
                if (tick) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q + BW'(1);
                    adv_d     = (bit_cnt_q != LAST_BIT);
                    state_d   = LO;
                end
            end
            GAP: begin
                if (tick) begin
                    busy_d  = 1'b0;
                    mosi_d  = 1'b0;
                    state_d = IDLE;
                end
            end
`ifdef SPI_MASTER_CS_HOLD_EN
            HOLD: begin
                // Chained transfer: cs_n is already low.
                if (start) begin
                    tx_sh_d   = tx_data;
                    mosi_d    = tx_data[DATA_W-1];
                    busy_d    = 1'b1;
                    bit_cnt_d = '0;
                    hold_d    = hold;
                    state_d   = LO;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign rx_data = rx_data_q;
    assign sclk    = sclk_q;
    assign cs_n    = cs_n_q;
    assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master with a shift-register SPI slave model per instance.
// Instance a uses CLK_DIV=4, instance b uses CLK_DIV=2.
module tb_spi_master;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] tx_data;
    logic [7:0] slave_preload;
    logic       use_b;
`ifdef SPI_MASTER_CS_HOLD_EN
    logic       hold;
`endif

    logic       a_busy, a_done, a_sclk, a_cs_n, a_mosi, a_miso;
    logic [7:0] a_rx;
    logic       b_busy, b_done, b_sclk, b_cs_n, b_mosi, b_miso;
    logic [7:0] b_rx;
    logic [7:0] sa_sr, sb_sr;

    logic       busy, done, sclk, cs_n, mosi;
    logic [7:0] rx_data, slave_sr;

    int checks;
    int errors;

    spi_master #(.CLK_DIV(4), .DATA_W(8)) u_a (
        .clk     (clk),
        .rst     (rst),
        .start   (start & ~use_b),
`ifdef SPI_MASTER_CS_HOLD_EN
        .hold    (hold),
`endif
        .tx_data (tx_data),
        .busy    (a_busy),
        .done    (a_done),
        .rx_data (a_rx),
        .sclk    (a_sclk),
        .cs_n    (a_cs_n),
        .mosi    (a_mosi),
        .miso    (a_miso)
    );

    spi_master #(.CLK_DIV(2), .DATA_W(8)) u_b (
        .clk     (clk),
        .rst     (rst),
        .start   (start & use_b),
`ifdef SPI_MASTER_CS_HOLD_EN
        .hold    (hold),
`endif
        .tx_data (tx_data),
        .busy    (b_busy),
        .done    (b_done),
        .rx_data (b_rx),
        .sclk    (b_sclk),
        .cs_n    (b_cs_n),
        .mosi    (b_mosi),
        .miso    (b_miso)
    );

    // Slave: preload on cs_n fall, shift mosi in on each sclk fall.
    always @(negedge a_cs_n) sa_sr <= slave_preload;
    always @(negedge a_sclk) if (!a_cs_n) sa_sr <= {sa_sr[6:0], a_mosi};
    assign a_miso = a_cs_n ? 1'b0 : sa_sr[7];

    always @(negedge b_cs_n) sb_sr <= slave_preload;
    always @(negedge b_sclk) if (!b_cs_n) sb_sr <= {sb_sr[6:0], b_mosi};
    assign b_miso = b_cs_n ? 1'b0 : sb_sr[7];

    assign busy     = use_b ? b_busy : a_busy;
    assign done     = use_b ? b_done : a_done;
    assign sclk     = use_b ? b_sclk : a_sclk;
    assign cs_n     = use_b ? b_cs_n : a_cs_n;
    assign mosi     = use_b ? b_mosi : a_mosi;
    assign rx_data  = use_b ? b_rx : a_rx;
    assign slave_sr = use_b ? sb_sr : sa_sr;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transfer, cycle 0 = the cycle start is sampled.
    task automatic xfer(input logic [7:0] tx, input logic hv,
                        input logic [7:0] exp_rx, input bit inject);
        int cdiv, n, k, nd, n_done, n_busy, t_done, t_busy;
        logic [7:0] got;
        logic ps, ps2, pm;
        cdiv   = use_b ? 2 : 4;
        t_done = 1 + (2 * 8 + 1) * cdiv;
        t_busy = hv ? t_done : 1 + (2 * 8 + 2) * cdiv;
        n = 0; k = 0; nd = 0; n_done = -1; n_busy = -1; got = '0;
        @(negedge clk);
        start = 1'b1;
        tx_data = tx;
`ifdef SPI_MASTER_CS_HOLD_EN
        hold = hv;
`endif
        ps = sclk; ps2 = sclk; pm = mosi;
        while (n < 400 && n_busy < 0) begin
            @(negedge clk);
            n++;
            start = inject && (n == 5 || n == 40);
            tx_data = 8'($urandom);
            if (n == 1) begin
                checks++;
                if (cs_n !== 1'b0 || busy !== 1'b1 || mosi !== tx[7]) begin
                    errors++;
                    $display("FAIL accept: cs_n=%b busy=%b mosi=%b want 0 1 %b",
                             cs_n, busy, mosi, tx[7]);
                end
            end
            if (sclk && !ps) begin
                checks++;
                if (n != 1 + (2 * k + 1) * cdiv) begin
                    errors++;
                    $display("FAIL rise_time: edge %0d at %0d want %0d",
                             k, n, 1 + (2 * k + 1) * cdiv);
                end
                got = {got[6:0], mosi};
                k++;
            end
            if (n > 1 && busy && mosi !== pm) begin
                checks++;
                if (!(ps === 1'b0 && ps2 === 1'b1)) begin
                    errors++;
                    $display("FAIL mosi_timing: mosi moved at %0d, not after fall", n);
                end
            end
            if (done) begin
                nd++;
                if (n_done < 0) n_done = n;
            end
            if (!busy) n_busy = n;
            ps2 = ps; ps = sclk; pm = mosi;
        end
        start = 1'b0;
        repeat (2 * cdiv) begin
            @(negedge clk);
            if (done) nd++;
        end
        checks++;
        if (nd != 1 || n_done != t_done) begin
            errors++;
            $display("FAIL done: %0d pulses at %0d want 1 at %0d", nd, n_done, t_done);
        end
        checks++;
        if (n_busy != t_busy) begin
            errors++;
            $display("FAIL busy_fall: at %0d want %0d", n_busy, t_busy);
        end
        checks++;
        if (k != 8 || got !== tx) begin
            errors++;
            $display("FAIL mosi_stream: %0d bits %h want 8 bits %h", k, got, tx);
        end
        checks++;
        if (rx_data !== exp_rx) begin
            errors++;
            $display("FAIL rx_data: got %h want %h", rx_data, exp_rx);
        end
        checks++;
        if (slave_sr !== tx) begin
            errors++;
            $display("FAIL slave_capture: got %h want %h", slave_sr, tx);
        end
        checks++;
        if (cs_n !== ~hv) begin
            errors++;
            $display("FAIL cs_n_end: got %b want %b", cs_n, ~hv);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            use_b = i[0];
            #1;
            checks++;
            if ({cs_n, sclk, mosi, busy, done} !== 5'b10000 || rx_data !== 8'h00) begin
                errors++;
                $display("FAIL reset_%0d: cs,sclk,mosi,busy,done=%b rx=%h want 10000 00",
                         i, {cs_n, sclk, mosi, busy, done}, rx_data);
            end
        end
        use_b = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (cs_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: cs_n=%b busy=%b want 1 0", cs_n, busy);
        end
    endtask

    task automatic test_basic;
        use_b = 1'b0;
        slave_preload = 8'hAA;
        xfer(8'h3C, 1'b0, 8'hAA, 1'b0);
    endtask

    task automatic test_reset_mid;
        int rises, n;
        logic ps;
        use_b = 1'b0;
        slave_preload = 8'hAA;
        @(negedge clk);
        start = 1'b1;
        tx_data = 8'($urandom);
        rises = 0; n = 0; ps = sclk;
        while (rises < 4 && n < 200) begin
            @(negedge clk);
            start = 1'b0;
            n++;
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({cs_n, sclk, busy, done, mosi} !== 5'b10000 || rx_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_mid: cs,sclk,busy,done,mosi=%b rx=%h want 10000 00",
                     {cs_n, sclk, busy, done, mosi}, rx_data);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        xfer(8'($urandom), 1'b0, 8'hAA, 1'b0);
    endtask

    task automatic test_ignore_start;
        use_b = 1'b0;
        slave_preload = 8'hAA;
        xfer(8'hC3, 1'b0, 8'hAA, 1'b1);
    endtask

    task automatic test_back_to_back;
        int n, d1, d2, fall2, hi, k;
        logic [15:0] got;
        logic ps, pc;
        use_b = 1'b0;
        slave_preload = 8'hAA;
        @(negedge clk);
        start = 1'b1;
        tx_data = 8'hFF;
        n = 0; d1 = -1; d2 = -1; fall2 = -1; hi = 0; k = 0; got = '0;
        ps = sclk; pc = cs_n;
        while (n < 400 && d2 < 0) begin
            @(negedge clk);
            n++;
            if (sclk && !ps) begin
                got = {got[14:0], mosi};
                k++;
            end
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    tx_data = 8'h00;
                end else begin
                    d2 = n;
                end
            end
            if (d1 >= 0 && fall2 < 0 && cs_n) hi++;
            if (d1 >= 0 && fall2 < 0 && !cs_n && pc) fall2 = n;
            ps = sclk; pc = cs_n;
        end
        start = 1'b0;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (d1 != 69 || d2 != 73 + 69) begin
            errors++;
            $display("FAIL b2b_done: at %0d,%0d want 69,142", d1, d2);
        end
        // cs_n rises with done (69) and falls after the re-accept at 73.
        checks++;
        if (fall2 != 74 || hi != 5) begin
            errors++;
            $display("FAIL b2b_cs_gap: fall %0d high %0d want 74 and 5", fall2, hi);
        end
        checks++;
        if (k != 16 || got !== 16'hFF00) begin
            errors++;
            $display("FAIL b2b_stream: %0d bits %h want 16 bits ff00", k, got);
        end
        checks++;
        if (rx_data !== 8'hAA || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end: rx %h busy %b want aa 0", rx_data, busy);
        end
    endtask

    task automatic test_clkdiv2;
        use_b = 1'b1;
        slave_preload = 8'hAA;
        xfer(8'h81, 1'b0, 8'hAA, 1'b0);
        use_b = 1'b0;
    endtask

    task automatic test_random;
        logic [7:0] tx;
        for (int i = 0; i < 8; i++) begin
            use_b = 1'($urandom_range(0, 1));
            slave_preload = 8'($urandom);
            tx = 8'($urandom);
            xfer(tx, 1'b0, slave_preload, 1'b0);
        end
        use_b = 1'b0;
    endtask

`ifdef SPI_MASTER_CS_HOLD_EN
    task automatic test_hold;
        use_b = 1'b0;
        slave_preload = 8'hAA;
        xfer(8'h3C, 1'b1, 8'hAA, 1'b0);
        repeat (5) begin
            @(negedge clk);
            checks++;
            if (cs_n !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL hold_idle: cs_n=%b busy=%b want 0 0", cs_n, busy);
            end
        end
        xfer(8'h5A, 1'b0, 8'h3C, 1'b0);
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        start = 1'b0;
        tx_data = '0;
        use_b = 1'b0;
        slave_preload = 8'hAA;
`ifdef SPI_MASTER_CS_HOLD_EN
        hold = 1'b0;
`endif
        test_reset();
        test_basic();
        test_reset_mid();
        test_ignore_start();
        test_back_to_back();
        test_clkdiv2();
        test_random();
`ifdef SPI_MASTER_CS_HOLD_EN
        test_hold();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
